// File: rtl/dpram_burst_tran.sv
// Purpose : true dual-port RAM; each port runs fixed-length incrementing bursts from one start command.
// Latency : first beat one cycle after the start edge; read data registered, visible one cycle after its beat.
// Backpr. : none; both ports burst concurrently without stalls, burst_en low mid-burst aborts the burst.
//
// Ports (A shown, B identical):
//   clk, rst_n        clock, async active-low reset
//   burst_en_a        burst request level; a burst starts from IDLE, low during a burst aborts it
//   we_a              direction latched at start (1 = write)
//   burst_len_a       beats minus one, latched at start
//   base_addr_a       start address, latched at start; addresses wrap modulo the depth
//   din_a             write data, sampled on every write beat
//   dout_a            registered read data, holds between read beats

module dpram_burst_port #(
    parameter int ADDR_WIDTH = 6,
    parameter int LW         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  burst_en,
    input  logic                  we,
    input  logic [LW-1:0]         burst_len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  acc_vld,
    output logic                  acc_we,
    output logic [ADDR_WIDTH-1:0] acc_addr
);
    typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           off_q, off_d;
    logic                    we_q, we_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            off_q   <= off_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        off_d   = off_q;
        we_d    = we_q;
        acc_vld = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The start edge only captures the command; the first beat is on the next edge.
                if (burst_en) begin
                    base_d  = base_addr;
                    len_d   = burst_len;
                    we_d    = we;
                    off_d   = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!burst_en) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_vld = 1'b1;
                    off_d   = off_q + 1'b1;
                    if (off_q == len_q) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A level held high must not start another burst.
                if (!burst_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_we   = we_q;
    // Truncating add gives the modulo-depth wrap.
    assign acc_addr = base_q + ADDR_WIDTH'(off_q);
endmodule

module dpram_burst_tran #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 6,
    parameter int MAX_BURST_LEN = 4,
    parameter int LW            = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic                  burst_en_a,
    input  logic [LW-1:0]         burst_len_a,
    input  logic [ADDR_WIDTH-1:0] base_addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic                  burst_en_b,
    input  logic [LW-1:0]         burst_len_b,
    input  logic [ADDR_WIDTH-1:0] base_addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  acc_vld_a, acc_we_a, acc_vld_b, acc_we_b;
    logic [ADDR_WIDTH-1:0] acc_addr_a, acc_addr_b;
    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dpram_burst_port #(.ADDR_WIDTH(ADDR_WIDTH), .LW(LW)) u_port_a (
        .clk(clk), .rst_n(rst_n), .burst_en(burst_en_a), .we(we_a),
        .burst_len(burst_len_a), .base_addr(base_addr_a),
        .acc_vld(acc_vld_a), .acc_we(acc_we_a), .acc_addr(acc_addr_a)
    );

    dpram_burst_port #(.ADDR_WIDTH(ADDR_WIDTH), .LW(LW)) u_port_b (
        .clk(clk), .rst_n(rst_n), .burst_en(burst_en_b), .we(we_b),
        .burst_len(burst_len_b), .base_addr(base_addr_b),
        .acc_vld(acc_vld_b), .acc_we(acc_we_b), .acc_addr(acc_addr_b)
    );

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (acc_vld_b && acc_we_b) mem[acc_addr_b] <= din_b;
        if (acc_vld_a && acc_we_a) mem[acc_addr_a] <= din_a;
    end

    // Reads sample the array before this edge's writes land: read-before-write.
    always_comb begin
        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        if (acc_vld_a && !acc_we_a) dout_a_d = mem[acc_addr_a];
        if (acc_vld_b && !acc_we_b) dout_b_d = mem[acc_addr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
        end
    end

    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;
endmodule

// File: tb/tb_dpram_burst_tran.sv
module tb_dpram_burst_tran;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       we_a, burst_en_a, we_b, burst_en_b;
    logic [1:0] burst_len_a, burst_len_b;
    logic [5:0] base_addr_a, base_addr_b;
    logic [7:0] din_a, din_b, dout_a, dout_b;

    dpram_burst_tran dut (
        .clk(clk), .rst_n(rst_n),
        .we_a(we_a), .burst_en_a(burst_en_a), .burst_len_a(burst_len_a),
        .base_addr_a(base_addr_a), .din_a(din_a), .dout_a(dout_a),
        .we_b(we_b), .burst_en_b(burst_en_b), .burst_len_b(burst_len_b),
        .base_addr_b(base_addr_b), .din_b(din_b), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            act;
        logic            we;
        logic [5:0]      base;
        logic [1:0]      len;
        logic [3:0][7:0] d;
    } bcmd_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: memory image plus the value each dout must currently show.
    logic [7:0] mem_m [64];
    bit         wr_m  [64];
    logic [7:0] exp_a, exp_b;
    bit         ev_a, ev_b;
    bit         run_cmp = 1'b0;
    logic [7:0] obs_a [4];
    logic [7:0] obs_b [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            if (ev_a) check("dout_a_model", dout_a, exp_a);
            if (ev_b) check("dout_b_model", dout_b, exp_b);
        end
    end

    function automatic bcmd_t mk(input bit act, input bit we, input logic [5:0] base,
                                 input logic [1:0] len, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3);
        bcmd_t c;
        c.act = act; c.we = we; c.base = base; c.len = len;
        c.d[0] = d0; c.d[1] = d1; c.d[2] = d2; c.d[3] = d3;
        return c;
    endfunction

    // Drives one burst on each active port from a common start edge; extra keeps
    // burst_en high (with the original command re-presented) after the burst ends.
    task automatic burst(input bcmd_t a, input bcmd_t b, input int extra);
        int na, nb, n;
        logic [5:0] ad;
        na = a.act ? int'(a.len) + 1 : 0;
        nb = b.act ? int'(b.len) + 1 : 0;
        n  = ((na > nb) ? na : nb) + extra;
        burst_en_a = a.act; we_a = a.we; base_addr_a = a.base; burst_len_a = a.len; din_a = 8'h00;
        burst_en_b = b.act; we_b = b.we; base_addr_b = b.base; burst_len_b = b.len; din_b = 8'h00;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            if (k < na) begin
                we_a = ~a.we; base_addr_a = a.base ^ 6'h2A; burst_len_a = ~a.len; din_a = a.d[k];
            end else begin
                we_a = a.we; base_addr_a = a.base; burst_len_a = a.len; din_a = 8'h99;
            end
            if (k < nb) begin
                we_b = ~b.we; base_addr_b = b.base ^ 6'h15; burst_len_b = ~b.len; din_b = b.d[k];
            end else begin
                we_b = b.we; base_addr_b = b.base; burst_len_b = b.len; din_b = 8'h66;
            end
            @(posedge clk); #1;
            if (k < na && !a.we) begin
                ad = 6'(int'(a.base) + k); exp_a = mem_m[ad]; ev_a = wr_m[ad]; obs_a[k] = dout_a;
            end
            if (k < nb && !b.we) begin
                ad = 6'(int'(b.base) + k); exp_b = mem_m[ad]; ev_b = wr_m[ad]; obs_b[k] = dout_b;
            end
            if (k < nb && b.we) begin
                ad = 6'(int'(b.base) + k); mem_m[ad] = b.d[k]; wr_m[ad] = 1'b1;
            end
            if (k < na && a.we) begin
                ad = 6'(int'(a.base) + k); mem_m[ad] = a.d[k]; wr_m[ad] = 1'b1;
            end
        end
        burst_en_a = 1'b0; burst_en_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic obs_chk(input string nm, input bit pb, input int n, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_beat%0d", nm, k), pb ? obs_b[k] : obs_a[k], e[k]);
        end
    endtask

    bcmd_t none;

    initial begin
        none = mk(0, 0, 6'd0, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 64; i++) wr_m[i] = 1'b0;
        rst_n = 1'b0;
        we_a = 0; burst_en_a = 0; burst_len_a = 0; base_addr_a = 0; din_a = 0;
        we_b = 0; burst_en_b = 0; burst_len_b = 0; base_addr_b = 0; din_b = 0;
        exp_a = 8'h00; exp_b = 8'h00; ev_a = 1'b1; ev_b = 1'b1;
        run_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout_a", dout_a, 8'h00);
        check("reset_dout_b", dout_b, 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read on port A.
        burst(mk(1, 1, 6'd0, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44), none, 0);
        burst(mk(1, 0, 6'd0, 2'd3, 8'h0, 8'h0, 8'h0, 8'h0), none, 0);
        obs_chk("a_rd0", 0, 4, 8'h11, 8'h22, 8'h33, 8'h44);

        // Port B write/read at 16; port A region untouched.
        burst(none, mk(1, 1, 6'd16, 2'd3, 8'hAA, 8'hBB, 8'hCC, 8'hDD), 0);
        burst(none, mk(1, 0, 6'd16, 2'd3, 8'h0, 8'h0, 8'h0, 8'h0), 0);
        obs_chk("b_rd16", 1, 4, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        burst(mk(1, 0, 6'd0, 2'd3, 8'h0, 8'h0, 8'h0, 8'h0), none, 0);
        obs_chk("a_rd0_again", 0, 4, 8'h11, 8'h22, 8'h33, 8'h44);

        // Concurrent bursts on both ports.
        burst(mk(1, 1, 6'd32, 2'd2, 8'hE1, 8'hE2, 8'hE3, 8'h0),
              mk(1, 1, 6'd48, 2'd2, 8'hF1, 8'hF2, 8'hF3, 8'h0), 0);
        burst(mk(1, 0, 6'd32, 2'd2, 8'h0, 8'h0, 8'h0, 8'h0),
              mk(1, 0, 6'd48, 2'd2, 8'h0, 8'h0, 8'h0, 8'h0), 0);
        obs_chk("a_rd32", 0, 3, 8'hE1, 8'hE2, 8'hE3, 8'h0);
        obs_chk("b_rd48", 1, 3, 8'hF1, 8'hF2, 8'hF3, 8'h0);

        // Wrap-around with burst_en held high afterwards.
        burst(mk(1, 1, 6'd62, 2'd3, 8'h01, 8'h02, 8'h03, 8'h04), none, 3);
        burst(none, mk(1, 0, 6'd62, 2'd3, 8'h0, 8'h0, 8'h0, 8'h0), 0);
        obs_chk("b_rd62_wrap", 1, 4, 8'h01, 8'h02, 8'h03, 8'h04);
        burst(mk(1, 0, 6'd0, 2'd3, 8'h0, 8'h0, 8'h0, 8'h0), none, 0);
        obs_chk("a_rd0_after_wrap", 0, 4, 8'h03, 8'h04, 8'h33, 8'h44);

        // Same-address write collision: A wins.
        burst(mk(1, 1, 6'd5, 2'd0, 8'h5A, 8'h0, 8'h0, 8'h0),
              mk(1, 1, 6'd5, 2'd0, 8'hB5, 8'h0, 8'h0, 8'h0), 0);
        burst(mk(1, 0, 6'd5, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0), none, 0);
        obs_chk("a_rd5_collide", 0, 1, 8'h5A, 8'h0, 8'h0, 8'h0);

        // Read-before-write across ports.
        burst(mk(1, 1, 6'd7, 2'd0, 8'h70, 8'h0, 8'h0, 8'h0), none, 0);
        burst(mk(1, 0, 6'd7, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0),
              mk(1, 1, 6'd7, 2'd0, 8'h77, 8'h0, 8'h0, 8'h0), 0);
        obs_chk("a_rd7_old", 0, 1, 8'h70, 8'h0, 8'h0, 8'h0);
        burst(mk(1, 0, 6'd7, 2'd0, 8'h0, 8'h0, 8'h0, 8'h0), none, 0);
        obs_chk("a_rd7_new", 0, 1, 8'h77, 8'h0, 8'h0, 8'h0);

        // Reset in the middle of a 4-beat write over prefilled words.
        burst(none, mk(1, 1, 6'd8, 2'd3, 8'h10, 8'h11, 8'h12, 8'h13), 0);
        burst_en_a = 1'b1; we_a = 1'b1; base_addr_a = 6'd8; burst_len_a = 2'd3; din_a = 8'h00;
        @(posedge clk); #1;
        din_a = 8'h81;
        @(posedge clk); #1;
        mem_m[8] = 8'h81; wr_m[8] = 1'b1;
        din_a = 8'h82;
        #2;
        rst_n = 1'b0;
        #1;
        exp_a = 8'h00; exp_b = 8'h00; ev_a = 1'b1; ev_b = 1'b1;
        check("midrst_dout_a", dout_a, 8'h00);
        check("midrst_dout_b", dout_b, 8'h00);
        repeat (2) begin
            @(posedge clk); #1;
            din_a = din_a + 8'h01;
        end
        burst_en_a = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst(mk(1, 0, 6'd8, 2'd3, 8'h0, 8'h0, 8'h0, 8'h0), none, 0);
        obs_chk("a_rd8_after_rst", 0, 4, 8'h81, 8'h11, 8'h12, 8'h13);

        repeat (2) @(posedge clk);
        #1;
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpram_burst_tran.md
Name: dpram_burst_tran

Overview:
True dual-port synchronous RAM with two fully independent ports, A and B. Each port performs fixed-length, incrementing-address burst reads or writes from a single start command. Used as a shared buffer between two bus masters in one clock domain, where each master streams short bursts without issuing per-beat addresses.

Parameters:
DATA_WIDTH, 8, width of each memory word and of the din/dout ports.
ADDR_WIDTH, 6, address width; the memory depth is 2**ADDR_WIDTH words.
MAX_BURST_LEN, 4, maximum number of beats per burst; LW = $clog2(MAX_BURST_LEN).

Ports:
clk  in  1  single clock; all logic is on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
we_a  in  1  port A burst direction (1 = write, 0 = read); sampled at burst start.
burst_en_a  in  1  port A burst request/enable level.
burst_len_a  in  LW  port A burst length minus one (beats = burst_len_a+1).
base_addr_a  in  ADDR_WIDTH  port A burst start address.
din_a  in  DATA_WIDTH  port A write data, sampled once per write beat.
dout_a  out  DATA_WIDTH  port A registered read data.
we_b, burst_en_b, burst_len_b, base_addr_b, din_b, dout_b: same as port A, for port B.

Behaviour:
- Ports A and B are identical, independent per-port FSMs sharing one memory array of 2**ADDR_WIDTH x DATA_WIDTH.
- Reset (rst_n=0, asynchronous): dout_a=dout_b=0, both FSMs go to IDLE, offsets=0. Memory contents are not cleared by reset.
- FSM states: IDLE, BURST, HOLD.
- IDLE: on a rising edge with burst_en=1, latch base_addr, burst_len and we; set offset=0; go to BURST. No memory access happens on that edge.
- BURST: on each edge, perform one beat at addr = (base + offset) mod 2**ADDR_WIDTH.
  - Write beat: mem[addr] <= current din.
  - Read beat: dout <= mem[addr], so data is visible 1 cycle after the access edge.
  - offset increments after each beat.
  - After the beat where offset == latched len, go to HOLD.
  - If burst_en=0 at an edge while in BURST: abort, perform no beat, go to IDLE.
- HOLD: wait until burst_en=0, then go to IDLE. A burst_en level held high never retriggers a second burst.
- Burst latency: the first beat occurs 1 cycle after the start edge. A burst of N beats occupies edges start+1 .. start+N.
- Changes to base_addr, burst_len and we during BURST are ignored; din is not ignored.
- dout holds its last read value; write beats leave dout unchanged.
- Address wrap-around: base 62, len 3 (ADDR_WIDTH=6) accesses addresses 62, 63, 0, 1.
- Simultaneous writes to the same address on the same edge: port A's data is stored.
- Read and write to the same address on the same edge (different ports): the read returns the old data (read-before-write).
- Reads of never-written locations return X in simulation; the bench does not check them.
- Both ports may burst concurrently with no stalls.
- Reset asserted mid-burst aborts immediately; words already written are retained.

Test Plan:
- Port A write, base 0, len 3, din 11,22,33,44 on beats 1-4. Then port A read, base 0, len 3 -> dout_a = 11,22,33,44 on cycles 2-5 after the start edge.
- Port B write, base 16, len 3, data AA,BB,CC,DD. Then port B read -> dout_b = AA,BB,CC,DD; addresses 0-3 are unchanged (read via A: 11..44).
- Simultaneous A write base 32 (E1,E2,E3) and B write base 48 (F1,F2,F3), len 2. Then simultaneous reads -> dout_a = E1,E2,E3 and dout_b = F1,F2,F3 on the same cycles.
- Wrap test: port A write base 62, len 3, data 01..04; port B read base 62 -> 01,02,03,04 from addresses 62,63,0,1. burst_en held high 3 extra cycles -> no further writes; address 2 is unchanged.
- Collision test: A and B write address 5 together (A=5A, B=B5) -> reads back 5A. A reads address 7 while B writes 77 there -> A gets the old value; a later read gets 77.
- Reset mid-burst: assert rst_n=0 during beat 2 of a 4-beat write -> douts become 0, FSM is IDLE, beat 1 data is retained, beats 3-4 are not written. A new burst after release works normally.
